// File: rtl/const_bit_reader_pkg.sv
// const_bit_reader_pkg: shared constants and FSM encoding for the FIFO-to-mapper bit reader.
package const_bit_reader_pkg;
  localparam int DWIDTH = 8;
  localparam int MAXB = 15;
  localparam int BWIDTH = 4;
  localparam int BUFW = MAXB + DWIDTH;
  localparam int CWIDTH = $clog2(BUFW + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_LOAD} state_e;
endpackage

// File: rtl/const_bit_reader_bit_buffer.sv
// const_bit_reader_bit_buffer: LSB-first bit buffer; merge appends a byte above the held bits,
// consume strips the oldest need bits; both may happen on the same edge.
module const_bit_reader_bit_buffer
  import const_bit_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              merge_i,
  input  logic [DWIDTH-1:0] byte_i,
  input  logic              consume_i,
  input  logic [BWIDTH-1:0] need_i,
  output logic [MAXB-1:0]   bits_o,
  output logic [CWIDTH-1:0] avail_o
);
  logic [BUFW-1:0] buf_q, buf_d, merged, mask;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    merged = merge_i ? (buf_q | (BUFW'(byte_i) << cnt_q)) : buf_q;
    avail_o = merge_i ? cnt_q + CWIDTH'(DWIDTH) : cnt_q;
    mask = (BUFW'(1) << need_i) - BUFW'(1);
    bits_o = MAXB'(merged & mask);
    buf_d = clear_i ? '0 : consume_i ? merged >> need_i : merged;
    cnt_d = clear_i ? '0 : consume_i ? avail_o - CWIDTH'(need_i) : avail_o;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/const_bit_reader.sv
// const_bit_reader: pulls FIFO bytes into a bit buffer and returns 0..15 bits per request,
// fetching only when the buffered bits cannot satisfy the request.
module const_bit_reader
  import const_bit_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_data_i,
  output logic              fifo_re_o,
  input  logic              req_i,
  input  logic [BWIDTH-1:0] bits_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [MAXB-1:0]   data_o
);
  state_e state_q, state_d;
  logic [BWIDTH-1:0] need_q, need_d, need;
  logic [MAXB-1:0] data_q, data_d, bits;
  logic [CWIDTH-1:0] avail;
  logic valid_q, merge, consume;
  const_bit_reader_bit_buffer u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (flush_i),
    .merge_i  (merge),
    .byte_i   (fifo_data_i),
    .consume_i(consume),
    .need_i   (need),
    .bits_o   (bits),
    .avail_o  (avail)
  );
  always_comb begin
    ready_o = state_q == ST_IDLE;
    // a read during flush would lose a byte the flush is not meant to drop
    fifo_re_o = state_q == ST_FILL && !fifo_empty_i && !flush_i;
    merge = state_q == ST_LOAD && !flush_i;
    need = ready_o ? bits_i : need_q;
    consume = !flush_i && (merge || (ready_o && req_i)) && avail >= CWIDTH'(need);
    need_d = ready_o && req_i ? bits_i : need_q;
    data_d = consume ? bits : data_q;
    state_d = flush_i ? ST_IDLE
            : state_q == ST_IDLE ? (req_i && !consume ? ST_FILL : ST_IDLE)
            : state_q == ST_FILL ? (fifo_re_o ? ST_LOAD : ST_FILL)
            : (consume ? ST_IDLE : ST_FILL);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      need_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      need_q <= need_d;
      valid_q <= consume;
      data_q <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o = data_q;
endmodule
